// File: rtl/ula_alu8_if.sv
`default_nettype none
// ============================================================================
//  Module   : ula_alu8_if
//  Purpose  : Operand/selector/result bundle for the ula_alu8 ALU.
//  Revision : 1.0 - initial release
// ============================================================================
interface ula_alu8_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  Seletor;
    logic [15:0] S;

    modport master (output A, output B, output Seletor, input  S);
    modport slave  (input  A, input  B, input  Seletor, output S);
endinterface
`default_nettype wire

// File: rtl/ula_alu8.sv
`default_nettype none
// ============================================================================
//  Module   : ula_alu8
//  Purpose  : 8-bit, 16-function ALU with a registered 16-bit result.
//  Revision : 1.0 - initial release
// ============================================================================
module ula_alu8 (
    input  wire logic   clk,
    input  wire logic   rst,
    ula_alu8_if.slave   bus
);
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_MUL  = 4'b0010;
    localparam logic [3:0] c_OP_DIV  = 4'b0011;
    localparam logic [3:0] c_OP_SHL  = 4'b0100;
    localparam logic [3:0] c_OP_SHR  = 4'b0101;
    localparam logic [3:0] c_OP_ROL1 = 4'b0110;
    localparam logic [3:0] c_OP_ROR1 = 4'b0111;
    localparam logic [3:0] c_OP_AND  = 4'b1000;
    localparam logic [3:0] c_OP_OR   = 4'b1001;
    localparam logic [3:0] c_OP_XOR  = 4'b1010;
    localparam logic [3:0] c_OP_NOR  = 4'b1011;
    localparam logic [3:0] c_OP_NAND = 4'b1100;
    localparam logic [3:0] c_OP_XNOR = 4'b1101;
    localparam logic [3:0] c_OP_GT   = 4'b1110;
    localparam logic [3:0] c_OP_EQ   = 4'b1111;

    logic [15:0] w_a16;
    logic [15:0] w_b16;
    logic [15:0] w_result;
    logic [15:0] r_s;

    assign w_a16 = {8'b0, bus.A};
    assign w_b16 = {8'b0, bus.B};

    always_comb begin
        w_result = 16'h0000;
        case (bus.Seletor)
            c_OP_ADD:  w_result = w_a16 + w_b16;
            c_OP_SUB:  w_result = w_a16 - w_b16;
            c_OP_MUL:  w_result = w_a16 * w_b16;
            // Divide-by-zero is flagged with an all-ones result.
            c_OP_DIV:  w_result = (bus.B == 8'd0) ? 16'hFFFF
                                                  : {bus.A % bus.B, bus.A / bus.B};
            c_OP_SHL:  w_result = w_a16 << bus.B[2:0];
            c_OP_SHR:  w_result = {8'b0, bus.A >> bus.B[2:0]};
            c_OP_ROL1: w_result = {8'b0, bus.A[6:0], bus.A[7]};
            c_OP_ROR1: w_result = {8'b0, bus.A[0], bus.A[7:1]};
            c_OP_AND:  w_result = {8'b0, bus.A & bus.B};
            c_OP_OR:   w_result = {8'b0, bus.A | bus.B};
            c_OP_XOR:  w_result = {8'b0, bus.A ^ bus.B};
            c_OP_NOR:  w_result = {8'b0, ~(bus.A | bus.B)};
            c_OP_NAND: w_result = {8'b0, ~(bus.A & bus.B)};
            c_OP_XNOR: w_result = {8'b0, ~(bus.A ^ bus.B)};
            c_OP_GT:   w_result = {15'b0, bus.A > bus.B};
            c_OP_EQ:   w_result = {15'b0, bus.A == bus.B};
            default:   w_result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= 16'h0000;
        end else begin
            r_s <= w_result;
        end
    end

    assign bus.S = r_s;
endmodule
`default_nettype wire

// File: tb/tb_ula_alu8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_alu8
//  Purpose  : Directed and randomised self-checking bench for ula_alu8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_alu8;
    logic clk = 1'b0;
    logic rst;
    int   n_total  = 0;
    int   n_passed = 0;

    ula_alu8_if bus ();

    ula_alu8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference result computed with plain integer arithmetic.
    function automatic logic [15:0] model(input int op, input int a, input int b);
        int r;
        case (op)
            0:  r = a + b;
            1:  r = (a - b) & 32'hFFFF;
            2:  r = a * b;
            3:  r = (b == 0) ? 32'hFFFF : (((a % b) * 256) + (a / b));
            4:  r = (a * (1 << (b % 8))) & 32'hFFFF;
            5:  r = a / (1 << (b % 8));
            6:  r = ((a * 2) % 256) + (a / 128);
            7:  r = (a / 2) + ((a % 2) * 128);
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        n_total++;
        assert (bus.S === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, bus.S, exp);
    endtask

    // Called at a negedge: drive, let one rising edge capture, sample at the next negedge.
    task automatic apply(input string tag, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        bus.Seletor = op;
        bus.A       = a;
        bus.B       = b;
        @(posedge clk);
        @(negedge clk);
        check(tag, exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic [15:0] exp_prev;

        rst         = 1'b1;
        bus.A       = 8'($urandom);
        bus.B       = 8'($urandom);
        bus.Seletor = 4'($urandom);
        @(negedge clk);
        check("reset_edge1", 16'h0000);
        bus.Seletor = 4'b0010; bus.A = 8'hFF; bus.B = 8'hFF;
        @(negedge clk);
        check("reset_edge2", 16'h0000);
        rst = 1'b0;

        apply("add_24_31",   4'b0000, 8'd24,  8'd31,  16'd55);
        apply("add_68_79",   4'b0000, 8'd68,  8'd79,  16'd147);
        apply("add_254_245", 4'b0000, 8'd254, 8'd245, 16'd499);
        apply("add_255_251", 4'b0000, 8'd255, 8'd251, 16'd506);
        apply("add_carry",   4'b0000, 8'd255, 8'd255, 16'h01FE);
        apply("sub_200_55",  4'b0001, 8'd200, 8'd55,  16'd145);
        apply("sub_wrap",    4'b0001, 8'd1,   8'd2,   16'hFFFF);
        apply("mul_max",     4'b0010, 8'd255, 8'd255, 16'hFE01);
        apply("div_200_7",   4'b0011, 8'd200, 8'd7,   16'h041C);
        apply("div_by_zero", 4'b0011, 8'd9,   8'd0,   16'hFFFF);
        apply("div_a_lt_b",  4'b0011, 8'd5,   8'd9,   16'h0500);
        apply("shl_81_1",    4'b0100, 8'h81,  8'd1,   16'h0102);
        apply("shl_by_0",    4'b0100, 8'hA5,  8'd0,   16'h00A5);
        apply("shl_81_7",    4'b0100, 8'h81,  8'd7,   16'h4080);
        apply("shr_81_1",    4'b0101, 8'h81,  8'd1,   16'h0040);
        apply("rol1_81",     4'b0110, 8'h81,  8'h5A,  16'h0003);
        apply("ror1_81",     4'b0111, 8'h81,  8'h5A,  16'h00C0);
        apply("and",         4'b1000, 8'hF0,  8'h3C,  16'h0030);
        apply("or",          4'b1001, 8'hF0,  8'h3C,  16'h00FC);
        apply("xor",         4'b1010, 8'hF0,  8'h3C,  16'h00CC);
        apply("nor",         4'b1011, 8'hF0,  8'h3C,  16'h0003);
        apply("nand",        4'b1100, 8'hF0,  8'h3C,  16'h00CF);
        apply("xnor",        4'b1101, 8'hF0,  8'h3C,  16'h0033);
        apply("gt_5_3",      4'b1110, 8'd5,   8'd3,   16'h0001);
        apply("gt_3_3",      4'b1110, 8'd3,   8'd3,   16'h0000);
        apply("eq_3_3",      4'b1111, 8'd3,   8'd3,   16'h0001);
        apply("eq_3_4",      4'b1111, 8'd3,   8'd4,   16'h0000);

        // Mid-stream reset clears S on that edge; next edge loads again.
        bus.Seletor = 4'b0000; bus.A = 8'd100; bus.B = 8'd100;
        rst = 1'b1;
        @(negedge clk);
        check("reset_midstream", 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_load", 16'd200);

        // Back-to-back: a new code every cycle, each result one edge later.
        for (int i = 0; i < 16; i++) begin
            op = 4'(i);
            a  = 8'($urandom);
            b  = 8'($urandom);
            bus.Seletor = op; bus.A = a; bus.B = b;
            exp_prev = model(i, int'(a), int'(b));
            @(negedge clk);
            check($sformatf("b2b_op%0d", i), exp_prev);
        end

        // Randomised sweep; operands change every cycle with no idle edges.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom);
            a  = 8'($urandom);
            b  = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            if (i % 7 == 0) b = a;
            bus.Seletor = op; bus.A = a; bus.B = b;
            @(negedge clk);
            check($sformatf("rand%0d_op%0d_a%0d_b%0d", i, op, a, b),
                  model(int'(op), int'(a), int'(b)));
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
`default_nettype wire
